mac_acc_sequencer: RTL and testbench
====================================

Name: mac_acc_sequencer

Overview:
- Initiator/consumer for the MAC's pipelined adder: accepts a stream of products, drives the external adder's a/b/valid inputs, and absorbs its results.
- Hides the adder's feedback latency by interleaving partial sums across ADD_LATENCY+2 lanes.
- On the vector's last element it drains in-flight adds, reduces the lanes serially through the same adder, and emits one accumulated result.

Parameters:
- WIDTH, 32, data width of products, adder operands and result.
- ADD_LATENCY, 3, cycles from adder input valid to adder output valid (must match the adder instance).
- NUM_LANES (localparam), ADD_LATENCY+2, number of partial-sum lanes.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_prod  in  WIDTH  product operand
- i_prod_valid  in  1  product valid
- i_prod_last  in  1  marks final product of a vector
- o_prod_ready  out  1  block accepts product this cycle
- o_adder_a  out  WIDTH  adder operand a (registered)
- o_adder_b  out  WIDTH  adder operand b (registered)
- o_adder_valid  out  1  adder input valid (registered)
- i_adder_val  in  WIDTH  adder result
- i_adder_valid  in  1  adder result valid
- o_acc_val  out  WIDTH  accumulated vector sum, held until next result
- o_acc_valid  out  1  one-cycle pulse, o_acc_val is new
- o_err  out  1  sticky adder protocol error

Behaviour:
- Reset, synchronous, active-high on i_rst; clock i_clk. All outputs, lanes, counters, tag pipe and state clear to 0; state ACCUM. Reset mid-operation abandons the vector; adder results arriving after reset are ignored.
- States: ACCUM, DRAIN, RED_ISSUE, RED_WAIT.
- ACCUM: o_prod_ready=1, and 0 in all other states.
  - Accept on i_prod_valid & o_prod_ready at cycle t: next edge sets o_adder_a=i_prod, o_adder_b=lane[slot], o_adder_valid=1.
  - Push slot into the tag pipe (depth ADD_LATENCY); slot advances mod NUM_LANES; in-flight count +1.
  - If i_prod_last, go to DRAIN.
  - No accept: o_adder_valid=0.
- Writeback: when the tag pipe output is valid, i_adder_valid must be 1. lane[tag] <= i_adder_val; in-flight count -1.
  - Lane reuse spacing is at least NUM_LANES cycles, so no bypass is needed.
- o_err: set and held until reset if i_adder_valid differs from the tag-pipe valid in any cycle. Mismatched results are not written.
- DRAIN: when in-flight==0, go to RED_ISSUE. acc <= lane[0]; reduction index r=1.
- RED_ISSUE (cycle c): next edge drives o_adder_a=acc, o_adder_b=lane[r], o_adder_valid=1 for one cycle. Go to RED_WAIT.
- RED_WAIT: on i_adder_valid (cycle c+1+ADD_LATENCY), acc <= i_adder_val.
  - If r==NUM_LANES-1: at that edge set o_acc_val=i_adder_val and o_acc_valid=1; clear all lanes; slot=0; go to ACCUM.
  - Otherwise r+1 and go to RED_ISSUE.
- Latency: last product accepted at T, default params → o_acc_valid high at T+26.
  - Derivation: in-flight clears end of T+4; RED_ISSUE at T+6; 4 reductions × 5 cycles.
  - o_prod_ready high again at T+26.
- Arithmetic: all sums modulo 2^WIDTH, with no overflow flag.
- Boundary cases:
  - Vectors shorter than NUM_LANES leave unused lanes at 0; a single-element vector is valid.
  - i_prod_last with i_prod_valid=0 is ignored.
  - Products offered in non-ACCUM states are not accepted and must be held by the source.
  - Valid bubbles within a vector are allowed, with no effect on the result.
  - Back-to-back vectors: the first product of the next vector is acceptable in the o_acc_valid cycle.

Test Plan:
- Products 1..8 back-to-back, last on 8, with a 3-cycle pipelined adder model → o_acc_val=36, o_acc_valid exactly at T+26, o_err=0.
- Single product 0x7 with last → o_acc_val=0x7; o_adder_valid pulses 1 + 4 times total.
- Products 0xFFFFFFFF, 0x2 last → o_acc_val=0x00000001 (wrap).
- Products 10,20,30,40,50,60 with random valid gaps, then immediately a second vector 5,5 last → results 210 then 10; o_prod_ready low from accept of last until the o_acc_valid cycle.
- Assert i_rst during RED_WAIT of a vector, then send 3,4 last → all outputs 0 after reset, o_acc_val=7, o_err=0.
- Inject a spurious i_adder_valid with no issue outstanding → o_err=1 from the next cycle and held until reset; lanes unchanged.

Source files
------------

// File: rtl/mac_acc_sequencer.sv
// Feeds a product stream through an external pipelined adder using interleaved
// partial-sum lanes, then folds the lanes serially into one result per vector.
module mac_acc_sequencer #(
  parameter int WIDTH       = 32,
  parameter int ADD_LATENCY = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_prod,
  input  logic             i_prod_valid,
  input  logic             i_prod_last,
  output logic             o_prod_ready,
  output logic [WIDTH-1:0] o_adder_a,
  output logic [WIDTH-1:0] o_adder_b,
  output logic             o_adder_valid,
  input  logic [WIDTH-1:0] i_adder_val,
  input  logic             i_adder_valid,
  output logic [WIDTH-1:0] o_acc_val,
  output logic             o_acc_valid,
  output logic             o_err
);

  localparam int NUM_LANES = ADD_LATENCY + 2;
  localparam int SW = $clog2(NUM_LANES);
  localparam int CW = $clog2(NUM_LANES + 1);
  localparam int GW = $clog2(ADD_LATENCY + 1);
  localparam logic [SW-1:0] LAST_LANE = SW'(NUM_LANES - 1);

  typedef enum logic [1:0] {ACCUM, DRAIN, RED_ISSUE, RED_WAIT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] lane [NUM_LANES];
  logic [SW-1:0]    slot;
  logic [SW-1:0]    red_idx;
  logic [CW-1:0]    inflight;
  logic [WIDTH-1:0] acc;
  logic [GW-1:0]    settle;

  // Tag pipe: stage 0 lines up with o_adder_valid, the last stage with the adder result.
  logic             pipe_v   [ADD_LATENCY+1];
  logic             pipe_red [ADD_LATENCY+1];
  logic [SW-1:0]    pipe_tag [ADD_LATENCY+1];

  logic accept, tag_valid, settled, wb_match, lane_wb, red_done, proto_err;

  assign o_prod_ready = (state == ACCUM);
  assign accept       = o_prod_ready & i_prod_valid;
  assign tag_valid    = pipe_v[ADD_LATENCY];
  // Results of adds issued before a reset can still arrive for ADD_LATENCY cycles.
  assign settled      = (settle == GW'(ADD_LATENCY));
  assign wb_match     = tag_valid & i_adder_valid;
  assign lane_wb      = wb_match & ~pipe_red[ADD_LATENCY];
  assign red_done     = wb_match & pipe_red[ADD_LATENCY];
  assign proto_err    = settled & (i_adder_valid != tag_valid);

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:     if (accept && i_prod_last) state_next = DRAIN;
      DRAIN:     if (inflight == '0) state_next = RED_ISSUE;
      RED_ISSUE: state_next = RED_WAIT;
      RED_WAIT:  if (red_done) state_next = (red_idx == LAST_LANE) ? ACCUM : RED_ISSUE;
      default:   state_next = ACCUM;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= ACCUM;
      slot          <= '0;
      red_idx       <= '0;
      inflight      <= '0;
      acc           <= '0;
      settle        <= '0;
      o_adder_a     <= '0;
      o_adder_b     <= '0;
      o_adder_valid <= 1'b0;
      o_acc_val     <= '0;
      o_acc_valid   <= 1'b0;
      o_err         <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) lane[i] <= '0;
      for (int k = 0; k <= ADD_LATENCY; k++) begin
        pipe_v[k]   <= 1'b0;
        pipe_red[k] <= 1'b0;
        pipe_tag[k] <= '0;
      end
    end else begin
      state         <= state_next;
      o_adder_valid <= 1'b0;
      o_acc_valid   <= 1'b0;
      if (!settled) settle <= settle + 1'b1;
      if (proto_err) o_err <= 1'b1;

      for (int k = 1; k <= ADD_LATENCY; k++) begin
        pipe_v[k]   <= pipe_v[k-1];
        pipe_red[k] <= pipe_red[k-1];
        pipe_tag[k] <= pipe_tag[k-1];
      end
      pipe_v[0]   <= 1'b0;
      pipe_red[0] <= 1'b0;
      pipe_tag[0] <= '0;

      case ({accept, lane_wb})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase

      if (lane_wb) lane[pipe_tag[ADD_LATENCY]] <= i_adder_val;

      case (state)
        ACCUM: begin
          if (accept) begin
            o_adder_a     <= i_prod;
            o_adder_b     <= lane[slot];
            o_adder_valid <= 1'b1;
            pipe_v[0]     <= 1'b1;
            pipe_tag[0]   <= slot;
            slot          <= (slot == LAST_LANE) ? '0 : slot + 1'b1;
          end
        end
        DRAIN: begin
          if (inflight == '0) begin
            acc     <= lane[0];
            red_idx <= SW'(1);
          end
        end
        RED_ISSUE: begin
          o_adder_a     <= acc;
          o_adder_b     <= lane[red_idx];
          o_adder_valid <= 1'b1;
          pipe_v[0]     <= 1'b1;
          pipe_red[0]   <= 1'b1;
        end
        RED_WAIT: begin
          if (red_done) begin
            acc <= i_adder_val;
            if (red_idx == LAST_LANE) begin
              o_acc_val   <= i_adder_val;
              o_acc_valid <= 1'b1;
              slot        <= '0;
              for (int i = 0; i < NUM_LANES; i++) lane[i] <= '0;
            end else begin
              red_idx <= red_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_acc_sequencer.sv
// Bench for mac_acc_sequencer: a 3-stage adder model, randomized vectors, and a
// per-cycle monitor comparing the DUT against plain vector sums and fixed latency.
module tb_mac_acc_sequencer;

  localparam int W = 32;
  localparam int RESULT_LAT = 26;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] prod;
  logic         prod_valid, prod_last, prod_ready;
  logic [W-1:0] adder_a, adder_b, adder_val;
  logic         adder_valid_o, adder_valid_i;
  logic [W-1:0] acc_val;
  logic         acc_valid, err;
  logic         inj = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  mac_acc_sequencer #(.WIDTH(W), .ADD_LATENCY(3)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_prod(prod), .i_prod_valid(prod_valid), .i_prod_last(prod_last),
    .o_prod_ready(prod_ready),
    .o_adder_a(adder_a), .o_adder_b(adder_b), .o_adder_valid(adder_valid_o),
    .i_adder_val(adder_val), .i_adder_valid(adder_valid_i),
    .o_acc_val(acc_val), .o_acc_valid(acc_valid), .o_err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pipelined adder model, never reset, so results in flight survive a DUT reset.
  logic [2:0]   av = '0;
  logic [W-1:0] as0 = '0, as1 = '0, as2 = '0;
  always @(posedge clk) begin
    av  <= {av[1:0], adder_valid_o};
    as0 <= adder_a + adder_b;
    as1 <= as0;
    as2 <= as1;
  end
  assign adder_valid_i = av[2] | inj;
  assign adder_val     = inj ? 32'h0000_DEAD : as2;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: running vector sum, expected results with due cycles.
  logic [W-1:0] exp_q[$];
  int           exp_t[$];
  logic [W-1:0] cur_sum = '0;
  logic [W-1:0] held = '0;
  logic [W-1:0] last_model_sum = '0;
  logic         busy = 1'b0;
  int           busy_end = 0;
  int           err_at = -1;
  int           pulses = 0;
  int           results = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_t.delete();
      cur_sum = '0;
      held    = '0;
      busy    = 1'b0;
      err_at  = -1;
    end else begin
      if (busy && cyc >= busy_end) busy = 1'b0;
      check("prod_ready", {31'b0, prod_ready}, {31'b0, !busy});
      if (exp_t.size() > 0 && cyc == exp_t[0]) begin
        check("acc_valid", {31'b0, acc_valid}, 32'd1);
        held = exp_q.pop_front();
        void'(exp_t.pop_front());
      end else begin
        check("acc_valid", {31'b0, acc_valid}, 32'd0);
      end
      if (acc_valid) results++;
      check("acc_val", acc_val, held);
      check("err", {31'b0, err}, {31'b0, (err_at >= 0 && cyc >= err_at)});
      if (adder_valid_o) pulses++;
      if (prod_valid && prod_ready) begin
        cur_sum = cur_sum + prod;
        if (prod_last) begin
          exp_q.push_back(cur_sum);
          exp_t.push_back(cyc + RESULT_LAT);
          last_model_sum = cur_sum;
          cur_sum  = '0;
          busy     = 1'b1;
          busy_end = cyc + RESULT_LAT;
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] v, input logic last, input int max_gap);
    int g;
    int n;
    g = $urandom_range(0, max_gap);
    repeat (g) begin
      prod_valid = 1'b0;
      prod_last  = 1'($urandom_range(0, 1));
      prod       = $urandom;
      @(posedge clk); #1;
    end
    prod = v; prod_valid = 1'b1; prod_last = last;
    n = 0;
    forever begin
      @(negedge clk);
      if (prod_ready) break;
      n++;
      if (n > 100) begin
        tests++; fails++;
        $display("FAIL ready_wait: ready stayed 0 for %0d cycles expected 1", n);
        break;
      end
    end
    @(posedge clk); #1;
    prod_valid = 1'b0; prod_last = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_t.size() != 0 || busy) && n < 300) begin
      @(posedge clk); n++;
    end
    check("idle_wait", {31'b0, busy}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_adder_valid", {31'b0, adder_valid_o}, 32'd0);
    check("rst_acc_valid", {31'b0, acc_valid}, 32'd0);
    check("rst_acc_val", acc_val, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int r0;
    int len;
    rst = 1'b1; prod = '0; prod_valid = 1'b0; prod_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("init_adder_a", adder_a, 32'd0);
    check("init_adder_b", adder_b, 32'd0);
    check("init_adder_valid", {31'b0, adder_valid_o}, 32'd0);
    check("init_acc_val", acc_val, 32'd0);
    check("init_err", {31'b0, err}, 32'd0);
    @(posedge clk); #1;

    // 1..8 back to back
    for (int i = 1; i <= 8; i++) send(W'(i), i == 8, 0);
    wait_idle();
    check("t1_model_sum", last_model_sum, 32'd36);
    check("t1_acc_val", acc_val, 32'd36);

    // single element: one accumulate add plus four reduction adds
    pulses = 0;
    send(32'h7, 1'b1, 0);
    wait_idle();
    check("t2_model_sum", last_model_sum, 32'h7);
    check("t2_acc_val", acc_val, 32'h7);
    check("t2_pulses", W'(pulses), 32'd5);

    // modular wrap
    send(32'hFFFF_FFFF, 1'b0, 0);
    send(32'h2, 1'b1, 0);
    wait_idle();
    check("t3_model_sum", last_model_sum, 32'h1);
    check("t3_acc_val", acc_val, 32'h1);

    // gapped vector immediately followed by a second one
    r0 = results;
    for (int i = 1; i <= 6; i++) send(W'(10 * i), i == 6, 3);
    send(32'd5, 1'b0, 0);
    send(32'd5, 1'b1, 0);
    wait_idle();
    check("t4_results", W'(results - r0), 32'd2);
    check("t4_acc_val", acc_val, 32'd10);

    // reset during the first reduction wait, with a result still in flight
    send(32'd1, 1'b0, 0);
    send(32'd2, 1'b1, 0);
    repeat (7) @(posedge clk);
    #1;
    do_reset();
    send(32'd3, 1'b0, 0);
    send(32'd4, 1'b1, 0);
    wait_idle();
    check("t5_acc_val", acc_val, 32'd7);
    check("t5_err", {31'b0, err}, 32'd0);

    // randomized vectors, sometimes chained back to back
    for (int v = 0; v < 8; v++) begin
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) send($urandom, i == len - 1, 2);
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();

    // spurious adder result: sticky error, lanes untouched
    @(posedge clk); #1;
    inj = 1'b1;
    err_at = cyc + 1;
    @(posedge clk); #1;
    inj = 1'b0;
    send(32'd3, 1'b0, 0);
    send(32'd4, 1'b1, 0);
    wait_idle();
    check("t6_acc_val", acc_val, 32'd7);
    check("t6_err_held", {31'b0, err}, 32'd1);
    do_reset();
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
